// File: rtl/fp_round_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pack_if
// Brief    : Operand/result handshake bundle for the fp_round_pack stage.
//            out_flags exists only when FP_ROUND_FLAGS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fp_round_pack_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W+1:0]       in_exp;
  logic [MAN_W:0]         in_mant;
  logic [2:0]             in_grs;
  logic                   in_zero;
  logic                   in_inf;
  logic                   in_nan;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
`ifdef FP_ROUND_FLAGS_EN
  logic [2:0]             out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_grs, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_grs, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
`else
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_grs, in_zero, in_inf, in_nan, out_ready,
    input  in_ready, out_valid, out_result
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_grs, in_zero, in_inf, in_nan, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pack
// Brief    : Final FP adder stage. Stage 1 rounds to nearest-even and folds a
//            rounding carry into the exponent; stage 2 classifies NaN / inf /
//            zero / overflow / underflow and packs {sign, exp, frac}.
//            Two-deep valid/ready pipeline, one result per cycle.
//            Optional macro FP_ROUND_FLAGS_EN adds out_flags
//            {overflow, underflow, inexact} aligned with out_result.
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  fp_round_pack_if.slave      bus
);

  // Internal exponent carries one extra bit so a carry out of the largest
  // representable input exponent cannot wrap negative.
  localparam int             XW      = EXP_W + 3;
  localparam logic [XW-1:0]  EXP_MAX = XW'((1 << EXP_W) - 1);

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_advance;
  logic                 in_accept;

  logic                 s1_sign;
  logic                 s1_zero;
  logic                 s1_inf;
  logic                 s1_nan;
  logic [XW-1:0]        s1_exp;
  logic [MAN_W-1:0]     s1_frac;

  logic                 rnd_inc;
  logic [MAN_W+1:0]     rnd_sum;
  logic [XW-1:0]        rnd_exp;
  logic [MAN_W-1:0]     rnd_frac;

  logic                 exp_hi;
  logic                 exp_lo;
  logic [EXP_W+MAN_W:0] pack_result;
  logic [EXP_W+MAN_W:0] s2_result;

`ifdef FP_ROUND_FLAGS_EN
  logic                 s1_inexact;
  logic [2:0]           pack_flags;
  logic [2:0]           s2_flags;
`endif

  // Stage 1 may load whenever stage 2 is empty or draining this cycle.
  assign s1_advance   = !s2_valid | bus.out_ready;
  assign bus.in_ready = !s1_valid | s1_advance;
  assign in_accept    = bus.in_valid & bus.in_ready;

  // Round to nearest-even; a carry out of the mantissa renormalizes by one.
  always_comb begin
    rnd_inc = bus.in_grs[2] & (bus.in_grs[1] | bus.in_grs[0] | bus.in_mant[0]);
    rnd_sum = {1'b0, bus.in_mant} + {{(MAN_W+1){1'b0}}, rnd_inc};
    rnd_exp = {bus.in_exp[EXP_W+1], bus.in_exp};
    if (rnd_sum[MAN_W+1]) begin
      rnd_frac = rnd_sum[MAN_W:1];
      rnd_exp  = rnd_exp + XW'(1);
    end else begin
      rnd_frac = rnd_sum[MAN_W-1:0];
    end
  end

  // Stage 1 register: rounded operand plus pass-through flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_inf     <= 1'b0;
      s1_nan     <= 1'b0;
      s1_exp     <= '0;
      s1_frac    <= '0;
`ifdef FP_ROUND_FLAGS_EN
      s1_inexact <= 1'b0;
`endif
    end else begin
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (in_accept) begin
        s1_sign    <= bus.in_sign;
        s1_zero    <= bus.in_zero;
        s1_inf     <= bus.in_inf;
        s1_nan     <= bus.in_nan;
        s1_exp     <= rnd_exp;
        s1_frac    <= rnd_frac;
`ifdef FP_ROUND_FLAGS_EN
        s1_inexact <= |bus.in_grs;
`endif
      end
    end
  end

  // Classify by priority NaN > inf/overflow > zero/underflow > normal, then pack.
  always_comb begin
    exp_hi      = !s1_exp[XW-1] && (s1_exp >= EXP_MAX);
    exp_lo      = s1_exp[XW-1] || (s1_exp == '0);
    pack_result = {s1_sign, s1_exp[EXP_W-1:0], s1_frac};
`ifdef FP_ROUND_FLAGS_EN
    pack_flags  = {2'b00, s1_inexact};
`endif
    if (s1_nan) begin
      pack_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_ROUND_FLAGS_EN
      pack_flags  = 3'b000;
`endif
    end else if (s1_inf || exp_hi) begin
      pack_result = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_ROUND_FLAGS_EN
      pack_flags  = (s1_inf || s1_zero) ? 3'b000 : 3'b101;
`endif
    end else if (s1_zero || exp_lo) begin
      pack_result = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
`ifdef FP_ROUND_FLAGS_EN
      pack_flags  = s1_zero ? 3'b000 : 3'b011;
`endif
    end
  end

  // Stage 2 register: holds the packed word stable under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
`ifdef FP_ROUND_FLAGS_EN
      s2_flags  <= 3'b000;
`endif
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= pack_result;
`ifdef FP_ROUND_FLAGS_EN
        s2_flags  <= pack_flags;
`endif
      end
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_result = s2_result;
`ifdef FP_ROUND_FLAGS_EN
  assign bus.out_flags  = s2_flags;
`endif

endmodule
`default_nettype wire
